// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_COLS-1:0] COLS_IDLE = 4'b1111;
  localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'b1111;

  // Active-low one-hot column drive for a column index.
  function automatic logic [NUM_COLS-1:0] col_onehot_n(input logic [1:0] idx);
    logic [NUM_COLS-1:0] pat;
    pat      = COLS_IDLE;
    pat[idx] = 1'b0;
    return pat;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// rtl/keypad_row_sync.sv - two-flop synchronizer for the asynchronous keypad rows
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] i_rows,
  output logic [NUM_ROWS-1:0] o_rows_s
);

  logic [NUM_ROWS-1:0] r_meta;
  logic [NUM_ROWS-1:0] r_sync;

  // Two flops in series; reset to the released (pulled-up) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= ROWS_IDLE;
      r_sync <= ROWS_IDLE;
    end else begin
      r_meta <= i_rows;
      r_sync <= r_meta;
    end
  end

  assign o_rows_s = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 1200,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  // Settling below 3 cycles would sample rows before the synchronizer has caught up.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
  localparam int DEB_EFF    = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CNT_MAX    = (SETTLE_EFF > DEB_EFF) ? SETTLE_EFF : DEB_EFF;
  localparam int CNT_W      = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_EFF - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEB_EFF - 1);

  scan_state_t         r_state;
  logic [1:0]          r_col_idx;
  logic [1:0]          r_row;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_COLS-1:0] r_cols;
  logic [3:0]          r_key_code;
  logic                r_key_valid;
  logic                r_key_held;

  logic [NUM_ROWS-1:0] w_rows_s;
  logic [1:0]          w_row_first;
  logic [1:0]          w_col_next;
  logic                w_row_level;

  keypad_row_sync u_row_sync (
    .clk      (clk),
    .rst_n    (reset),
    .i_rows   (rows),
    .o_rows_s (w_rows_s)
  );

  // Lowest-numbered active row wins when several keys share a column.
  always_comb begin
    w_row_first = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!w_rows_s[i]) w_row_first = 2'(i);
    end
  end

  assign w_col_next  = r_col_idx + 2'd1;
  assign w_row_level = w_rows_s[r_row];

  // Scan/debounce/hold sequencer; column drive and key outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SCAN;
      r_col_idx   <= 2'd0;
      r_row       <= 2'd0;
      r_cnt       <= '0;
      r_cols      <= col_onehot_n(2'd0);
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt <= '0;
            if (w_rows_s == ROWS_IDLE) begin
              r_col_idx <= w_col_next;
              r_cols    <= col_onehot_n(w_col_next);
            end else begin
              r_row   <= w_row_first;
              r_state <= DEBOUNCE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (w_row_level) begin
            // Bounce: give up on this key and keep scanning from the next column.
            r_cnt     <= '0;
            r_col_idx <= w_col_next;
            r_cols    <= col_onehot_n(w_col_next);
            r_state   <= SCAN;
          end else if (r_cnt == DEBOUNCE_LAST) begin
            r_cnt       <= '0;
            r_key_valid <= 1'b1;
            r_key_code  <= {r_row, r_col_idx};
            r_key_held  <= 1'b1;
            r_state     <= HELD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        HELD: begin
          // Column stays frozen so only the accepted key is watched for release.
          if (!w_row_level) begin
            r_cnt <= '0;
          end else if (r_cnt == DEBOUNCE_LAST) begin
            r_cnt      <= '0;
            r_key_held <= 1'b0;
            r_col_idx  <= w_col_next;
            r_cols     <= col_onehot_n(w_col_next);
            r_state    <= SCAN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= SCAN;
          r_col_idx  <= 2'd0;
          r_cols     <= col_onehot_n(2'd0);
          r_cnt      <= '0;
          r_key_held <= 1'b0;
        end
      endcase
    end
  end

  assign cols      = r_cols;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - self-checking bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int DEB    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // pressed[r][c] = 1 means the key at row r, column c is physically down.
  logic [3:0][3:0] pressed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Keypad matrix: a row is pulled low only through a pressed key whose column is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r] & ~cols);
  end

  keypad_scan_ctrl #(
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Press the rows in rmask on column c, hold, optionally poke another column, then release.
  task automatic press_trial(input logic [3:0] rmask, input int c, input bit other);
    int d;
    int bad;
    int lowest;
    int n;
    int r2;
    int c2;
    logic [3:0] code;
    lowest = -1;
    for (int i = 0; i < 4; i++) if (rmask[i] && lowest < 0) lowest = i;
    code = 4'(lowest * 4 + c);

    d = 0;
    while (cols === col_pat(c) && d < 20) begin step(); d++; end
    check("scan_leaves_col", cols !== col_pat(c), 1);
    for (int r = 0; r < 4; r++) if (rmask[r]) pressed[r][c] = 1'b1;

    d = 0;
    while (cols !== col_pat(c) && d < 20) begin step(); d++; end
    check("scan_reaches_col", cols, col_pat(c));

    d = 0;
    bad = 0;
    while (key_valid !== 1'b1 && d < 40) begin
      step();
      d++;
      if (cols !== col_pat(c)) bad++;
    end
    check("press_latency", d, SETTLE + DEB);
    check("col_frozen_debounce", bad, 0);
    check("strobe_code", key_code, code);
    check("strobe_held", key_held, 1);
    check("strobe_cols", cols, col_pat(c));

    step();
    check("strobe_one_cycle", key_valid, 0);

    n = 15 + $urandom_range(0, 10);
    r2 = $urandom_range(0, 3);
    c2 = (c + 1 + $urandom_range(0, 2)) % 4;
    if (other) pressed[r2][c2] = 1'b1;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (key_valid !== 1'b0 || key_held !== 1'b1 || cols !== col_pat(c) || key_code !== code) bad++;
    end
    pressed[r2][c2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (key_valid !== 1'b0 || key_held !== 1'b1 || cols !== col_pat(c)) bad++;
    end
    check("held_steady", bad, 0);

    pressed = '0;
    d = 0;
    bad = 0;
    while (key_held !== 1'b0 && d < 40) begin
      step();
      d++;
      if (key_valid !== 1'b0) bad++;
    end
    check("release_latency", d, DEB + 2);
    check("no_second_strobe", bad, 0);
    check("cols_after_release", cols, col_pat((c + 1) % 4));
    check("code_kept", key_code, code);
  endtask

  initial begin
    int bad;
    int trans;
    int d;
    int rr;
    int cc;
    logic [3:0] prev;

    reset = 1'b0;
    pressed = '0;
    repeat (3) step();
    check("rst_cols", cols, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_code", key_code, 4'h0);

    // Idle scan: each column driven for SETTLE cycles in order.
    reset = 1'b1;
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      check("idle_cols", cols, col_pat((k / SETTLE) % 4));
      if (key_valid !== 1'b0 || key_held !== 1'b0) bad++;
    end
    check("idle_no_key", bad, 0);

    press_trial(4'b0010, 2, 1'b1);
    for (int t = 0; t < 6; t++) begin
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 3);
      press_trial(4'b0001 << rr, cc, 1'b1);
    end
    press_trial(4'b1001, 0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      press_trial(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0);
    end

    // Bouncing row1/col2: low 3 cycles, high 1 cycle.
    bad = 0;
    trans = 0;
    prev = cols;
    for (int i = 0; i < 160; i++) begin
      pressed[1][2] = (i % 4 != 3);
      step();
      if (key_valid !== 1'b0 || key_held !== 1'b0) bad++;
      if (prev === 4'b1011 && cols !== 4'b1011) begin
        trans++;
        if (cols !== 4'b0111) bad++;
      end
      prev = cols;
    end
    check("bounce_no_accept", bad, 0);
    check("bounce_scan_moves", trans > 0, 1);
    pressed = '0;
    repeat (30) step();
    check("bounce_idle_held", key_held, 0);

    // Reset while a key is held.
    rr = $urandom_range(0, 3);
    cc = $urandom_range(0, 3);
    pressed[rr][cc] = 1'b1;
    d = 0;
    while (key_valid !== 1'b1 && d < 60) begin step(); d++; end
    check("hold_pre_strobe", key_valid, 1);
    repeat (3) step();
    check("hold_pre_held", key_held, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_cols", cols, 4'b1110);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_code", key_code, 4'h0);
    pressed = '0;
    step();
    step();
    reset = 1'b1;
    bad = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("restart_cols", cols, col_pat((k / SETTLE) % 4));
      if (key_valid !== 1'b0 || key_held !== 1'b0) bad++;
    end
    check("restart_no_key", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
